// File: rtl/prom_op_sequencer.sv
// prom_op_sequencer
// Turns a host flash request (sector erase, page program, bulk erase) into the
// M25P16 command series on the SPI engine's 32-bit command port: Write Enable,
// the operation, then Read Status polling until Write-In-Progress clears or the
// poll budget is used up. While busy, this block is the only writer of that port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a request; req_ready high
// WREN_ISS  | wait for engine idle, then strobe Write Enable
// WREN_WAIT | wait for the engine to take and finish Write Enable
// OP_ISS    | wait for engine idle, then strobe SE / PP / BE
// OP_WAIT   | wait for the engine to take and finish the operation
// GAP       | idle spacing before the next Read Status
// POLL_ISS  | wait for engine idle, then strobe Read Status
// POLL_WAIT | wait for Read Status result, decide done / poll again
// DONE      | one-cycle done pulse, status valid
module prom_op_sequencer #(
    parameter int POLL_GAP   = 1000,
    parameter int MAX_POLLS  = 50000,
    parameter int ISSUE_WDOG = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_op,
    input  logic [23:0] i_req_addr,
    output logic        o_req_ready,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_status,
    output logic [15:0] o_poll_count,
    output logic [31:0] o_spi_cmd,
    output logic        o_spi_cmd_wen,
    input  logic        i_spi_busy,
    input  logic [31:0] i_spi_result
);

    localparam logic [31:0] CMD_WREN = 32'h0600_0000;
    localparam logic [31:0] CMD_BE   = 32'hC700_0000;
    localparam logic [31:0] CMD_RDSR = 32'h0500_0000;
    localparam logic [7:0]  OPC_SE   = 8'hD8;
    localparam logic [7:0]  OPC_PP   = 8'h02;

    localparam logic [1:0]  OP_SE    = 2'b01;
    localparam logic [1:0]  OP_PP    = 2'b10;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam logic [1:0]  ST_ABORTED = 2'b10;
    localparam logic [1:0]  ST_NORESP  = 2'b11;

    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int WDOG_W = (ISSUE_WDOG > 1) ? $clog2(ISSUE_WDOG) : 1;

    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP - 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(ISSUE_WDOG - 1);
    localparam logic [15:0]       POLL_MAX  = 16'(MAX_POLLS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN_ISS,
        S_WREN_WAIT,
        S_OP_ISS,
        S_OP_WAIT,
        S_GAP,
        S_POLL_ISS,
        S_POLL_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [23:0]         r_addr;
    logic                r_abort;
    logic                r_seen_busy;
    logic [GAP_W-1:0]    r_gap;
    logic [WDOG_W-1:0]   r_wdog;

    logic                w_abort;
    logic                w_wait_exit;
    logic                w_wdog_expired;
    logic                w_wip;
    logic [31:0]         w_op_cmd;
    logic                w_unused_result;

    // Abort counts as soon as it is sampled, not only a cycle later via the flag.
    assign w_abort        = r_abort | i_abort;
    assign w_wait_exit    = r_seen_busy & ~i_spi_busy;
    assign w_wdog_expired = ~r_seen_busy & ~i_spi_busy & (r_wdog == '0);
    assign w_wip          = i_spi_result[0];

    // Only the WIP bit of the status register matters here.
    assign w_unused_result = ^i_spi_result[31:1];

    // Command word for the latched operation.
    always_comb begin
        w_op_cmd = CMD_BE;
        case (r_op)
            OP_SE:   w_op_cmd = {OPC_SE, r_addr};
            OP_PP:   w_op_cmd = {OPC_PP, r_addr};
            default: w_op_cmd = CMD_BE;
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_addr        <= 24'h0;
            r_abort       <= 1'b0;
            r_seen_busy   <= 1'b0;
            r_gap         <= '0;
            r_wdog        <= '0;
            o_req_ready   <= 1'b1;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_status      <= ST_OK;
            o_poll_count  <= 16'h0;
            o_spi_cmd     <= 32'h0;
            o_spi_cmd_wen <= 1'b0;
        end else begin
            o_spi_cmd_wen <= 1'b0;
            o_done        <= 1'b0;

            if (r_state != S_IDLE && i_abort) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && i_req_op != 2'b00) begin
                        r_op         <= i_req_op;
                        r_addr       <= i_req_addr;
                        r_abort      <= 1'b0;
                        o_poll_count <= 16'h0;
                        o_status     <= ST_OK;
                        o_busy       <= 1'b1;
                        o_req_ready  <= 1'b0;
                        r_state      <= S_WREN_ISS;
                    end
                end

                S_WREN_ISS: begin
                    if (w_abort) begin
                        o_status <= ST_ABORTED;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (!i_spi_busy) begin
                        o_spi_cmd     <= CMD_WREN;
                        o_spi_cmd_wen <= 1'b1;
                        r_seen_busy   <= 1'b0;
                        r_wdog        <= WDOG_LOAD;
                        r_state       <= S_WREN_WAIT;
                    end
                end

                S_WREN_WAIT: begin
                    if (i_spi_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (w_wait_exit) begin
                        if (w_abort) begin
                            o_status <= ST_ABORTED;
                            o_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_OP_ISS;
                        end
                    end else if (w_wdog_expired) begin
                        o_status <= ST_NORESP;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end

                S_OP_ISS: begin
                    if (w_abort) begin
                        o_status <= ST_ABORTED;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (!i_spi_busy) begin
                        o_spi_cmd     <= w_op_cmd;
                        o_spi_cmd_wen <= 1'b1;
                        r_seen_busy   <= 1'b0;
                        r_wdog        <= WDOG_LOAD;
                        r_state       <= S_OP_WAIT;
                    end
                end

                S_OP_WAIT: begin
                    if (i_spi_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (w_wait_exit) begin
                        if (w_abort) begin
                            o_status <= ST_ABORTED;
                            o_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end
                    end else if (w_wdog_expired) begin
                        o_status <= ST_NORESP;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end

                S_GAP: begin
                    if (w_abort) begin
                        o_status <= ST_ABORTED;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_gap == '0) begin
                        r_state <= S_POLL_ISS;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end

                S_POLL_ISS: begin
                    if (w_abort) begin
                        o_status <= ST_ABORTED;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (!i_spi_busy) begin
                        o_spi_cmd     <= CMD_RDSR;
                        o_spi_cmd_wen <= 1'b1;
                        r_seen_busy   <= 1'b0;
                        r_wdog        <= WDOG_LOAD;
                        if (o_poll_count != POLL_MAX) begin
                            o_poll_count <= o_poll_count + 16'd1;
                        end
                        r_state <= S_POLL_WAIT;
                    end
                end

                S_POLL_WAIT: begin
                    if (i_spi_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (w_wait_exit) begin
                        if (w_abort) begin
                            o_status <= ST_ABORTED;
                            o_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (!w_wip) begin
                            o_status <= ST_OK;
                            o_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (o_poll_count >= POLL_MAX) begin
                            o_status <= ST_TIMEOUT;
                            o_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end
                    end else if (w_wdog_expired) begin
                        o_status <= ST_NORESP;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end

                S_DONE: begin
                    o_busy      <= 1'b0;
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    o_busy      <= 1'b0;
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prom_op_sequencer.sv
// Testbench for prom_op_sequencer: a behavioural SPI engine model logs every
// command strobe; each scenario predicts the strobe list, status and poll count
// from the operation rules and compares against what the engine saw.
module tb_prom_op_sequencer;

    localparam int P_GAP  = 4;
    localparam int P_MAX  = 5;
    localparam int P_WDOG = 8;

    localparam logic [31:0] C_WREN = 32'h0600_0000;
    localparam logic [31:0] C_RDSR = 32'h0500_0000;
    localparam logic [31:0] C_BE   = 32'hC700_0000;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [23:0] req_addr = 24'h0;
    logic        req_ready;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] poll_count;
    logic [31:0] spi_cmd;
    logic        spi_cmd_wen;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [31:0] strobe_q[$];
    int          strobe_cyc[$];
    int          wip_cfg = 0;
    int          eng_lat = 1;
    bit          eng_mute = 1'b0;
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic [31:0] eng_result = 32'h0;
    int          eng_k;

    always #5 clk = ~clk;

    prom_op_sequencer #(
        .POLL_GAP   (P_GAP),
        .MAX_POLLS  (P_MAX),
        .ISSUE_WDOG (P_WDOG)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_b),
        .i_req_valid   (req_valid),
        .i_req_op      (req_op),
        .i_req_addr    (req_addr),
        .o_req_ready   (req_ready),
        .i_abort       (abort),
        .o_busy        (busy),
        .o_done        (done),
        .o_status      (status),
        .o_poll_count  (poll_count),
        .o_spi_cmd     (spi_cmd),
        .o_spi_cmd_wen (spi_cmd_wen),
        .i_spi_busy    (eng_busy),
        .i_spi_result  (eng_result)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // SPI engine model: busy for eng_lat clocks per command; RDSR reports WIP
    // for the first wip_cfg polls of the current operation.
    always @(posedge clk) begin
        if (!rst_b) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
        end else if (spi_cmd_wen === 1'b1) begin
            eng_k = 0;
            foreach (strobe_q[i]) if (strobe_q[i] == C_RDSR) eng_k++;
            strobe_q.push_back(spi_cmd);
            strobe_cyc.push_back(cyc);
            if (!eng_mute) begin
                eng_busy <= 1'b1;
                eng_cnt  <= eng_lat;
                if (spi_cmd == C_RDSR) eng_result <= {31'd0, (eng_k < wip_cfg)};
            end
        end else if (eng_busy) begin
            if (eng_cnt <= 1) eng_busy <= 1'b0;
            eng_cnt <= eng_cnt - 1;
        end
    end

    function automatic logic [31:0] op_word(input logic [1:0] op, input logic [23:0] a);
        case (op)
            2'b01:   return {8'hD8, a};
            2'b10:   return {8'h02, a};
            default: return C_BE;
        endcase
    endfunction

    task automatic wait_strobes(input int n, input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (strobe_q.size() >= n) break;
            @(negedge clk);
        end
        if (i == 2000) begin
            n_checks++; n_errors++;
            $display("FAIL %s wait_strobes: saw %0d strobes, needed %0d", name, strobe_q.size(), n);
        end
    endtask

    task automatic wait_engine_idle(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (eng_busy === 1'b0) break;
            @(negedge clk);
        end
        if (i == 2000) begin
            n_checks++; n_errors++;
            $display("FAIL %s wait_engine_idle: engine still busy", name);
        end
    endtask

    // abort_mode: 0 none, 1 during OP_WAIT, 2 during the first GAP
    task automatic run_op(input string name, input logic [1:0] op, input logic [23:0] addr,
                          input int wip, input int lat, input int abort_mode,
                          input bit mute, input bit poke);
        logic [31:0] exp_q[$];
        logic [1:0]  exp_st;
        int          exp_np;
        int          acc;
        bit          got;
        exp_q.push_back(C_WREN);
        exp_st = 2'b00;
        exp_np = 0;
        if (mute) begin
            exp_st = 2'b11;
        end else begin
            exp_q.push_back(op_word(op, addr));
            if (abort_mode != 0) begin
                exp_st = 2'b10;
            end else begin
                exp_np = (wip + 1 > P_MAX) ? P_MAX : wip + 1;
                exp_st = (wip + 1 > P_MAX) ? 2'b01 : 2'b00;
                repeat (exp_np) exp_q.push_back(C_RDSR);
            end
        end

        @(negedge clk);
        wip_cfg = wip; eng_lat = lat; eng_mute = mute;
        strobe_q.delete(); strobe_cyc.delete();
        req_valid = 1'b1; req_op = op; req_addr = addr; acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = 24'($urandom);

        if (poke) begin
            wait_strobes(1, name);
            req_valid = 1'b1; req_op = 2'b11;
            @(negedge clk);
            req_valid = 1'b0;
        end
        if (abort_mode == 1) begin
            wait_strobes(2, name);
            abort = 1'b1;
        end else if (abort_mode == 2) begin
            wait_strobes(2, name);
            wait_engine_idle(name);
            repeat (2) @(negedge clk);
            abort = 1'b1;
        end

        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL %s done: not seen within 3000 clocks, required a pulse", name); end
        n_checks++;
        if (status !== exp_st) begin n_errors++; $display("FAIL %s status: got %b, expected %b", name, status, exp_st); end
        n_checks++;
        if (poll_count !== 16'(exp_np)) begin n_errors++; $display("FAIL %s poll_count: got %0d, expected %0d", name, poll_count, exp_np); end
        if (abort_mode == 1) begin
            n_checks++;
            if (eng_busy !== 1'b0) begin n_errors++; $display("FAIL %s op_completed: engine busy %b at done, expected 0", name, eng_busy); end
        end
        abort = 1'b0;

        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || status !== exp_st) begin
            n_errors++;
            $display("FAIL %s after_done: ready=%b busy=%b done=%b status=%b, expected 1 0 0 %b",
                     name, req_ready, busy, done, status, exp_st);
        end

        repeat (3 * P_GAP + P_WDOG) @(negedge clk);
        n_checks++;
        if (strobe_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL %s strobe_count: got %0d, expected %0d", name, strobe_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++) begin
            n_checks++;
            if (strobe_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL %s strobe[%0d]: got %h, expected %h", name, i, strobe_q[i], exp_q[i]);
            end
        end
        if (strobe_cyc.size() > 0) begin
            n_checks++;
            if (strobe_cyc[0] != acc + 2) begin
                n_errors++; $display("FAIL %s first_strobe_latency: got %0d clocks, expected 1", name, strobe_cyc[0] - acc - 1);
            end
        end
        for (int i = 1; i < strobe_q.size(); i++) begin
            if (strobe_q[i] == C_RDSR) begin
                n_checks++;
                if (strobe_cyc[i] - strobe_cyc[i-1] < P_GAP + 1) begin
                    n_errors++; $display("FAIL %s rdsr_spacing[%0d]: got %0d clocks, expected >= %0d",
                                         name, i, strobe_cyc[i] - strobe_cyc[i-1], P_GAP + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || spi_cmd_wen !== 1'b0 ||
            spi_cmd !== 32'h0 || status !== 2'b00 || poll_count !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_values: busy=%b ready=%b done=%b wen=%b cmd=%h status=%b polls=%0d, expected 0 1 0 0 0 00 0",
                     busy, req_ready, done, spi_cmd_wen, spi_cmd, status, poll_count);
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_requests();
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        eng_mute = 1'b0;
        strobe_q.delete(); strobe_cyc.delete();
        req_valid = 1'b1; req_op = 2'b00; req_addr = 24'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || strobe_q.size() != 0 || done_cnt != d0) begin
            n_errors++;
            $display("FAIL op00_ignored: busy=%b ready=%b strobes=%0d dones=%0d, expected 0 1 0 0",
                     busy, req_ready, strobe_q.size(), done_cnt - d0);
        end
        run_op("busy_poke", 2'b01, 24'($urandom), 1, 2, 0, 1'b0, 1'b1);
        run_op("after_poke", 2'b10, 24'($urandom), 0, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_ops();
        logic [1:0] op;
        for (int k = 0; k < 8; k++) begin
            op = 2'($urandom_range(1, 3));
            run_op("random", op, 24'($urandom), int'($urandom_range(0, 6)),
                   int'($urandom_range(1, 4)), 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_gap();
        int n_before;
        @(negedge clk);
        wip_cfg = 100; eng_lat = 2; eng_mute = 1'b0;
        strobe_q.delete(); strobe_cyc.delete();
        req_valid = 1'b1; req_op = 2'b01; req_addr = 24'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        wait_strobes(3, "reset_gap");
        wait_engine_idle("reset_gap");
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || spi_cmd_wen !== 1'b0 || status !== 2'b00 || poll_count !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_mid_gap: busy=%b ready=%b wen=%b status=%b polls=%0d, expected 0 1 0 00 0",
                     busy, req_ready, spi_cmd_wen, status, poll_count);
        end
        n_before = strobe_q.size();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3 * P_GAP + 4) @(negedge clk);
        n_checks++;
        if (strobe_q.size() != n_before || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abandon: strobes after reset=%0d busy=%b, expected 0 0", strobe_q.size() - n_before, busy);
        end
        run_op("after_reset", 2'b11, 24'($urandom), 2, 3, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_op("se_012345", 2'b01, 24'h012345, 3, int'($urandom_range(1, 4)), 0, 1'b0, 1'b0);
        run_op("be_timeout", 2'b11, 24'($urandom), 1000, int'($urandom_range(1, 4)), 0, 1'b0, 1'b0);
        run_op("pp_abort_opwait", 2'b10, 24'h000100, 2, 4, 1, 1'b0, 1'b0);
        run_op("se_abort_gap", 2'b01, 24'($urandom), 3, 2, 2, 1'b0, 1'b0);
        run_op("wren_noresp", 2'($urandom_range(1, 3)), 24'($urandom), 0, 1, 0, 1'b1, 1'b0);
        test_ignored_requests();
        test_random_ops();
        test_reset_mid_gap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not complete, expected completion before 60000 clocks");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/prom_op_sequencer.md
# prom_op_sequencer

Sequences multi-command flash operations on the M25P16 SPI command engine for the FPGA1394_QLA board. A host request (sector erase, page program, bulk erase) becomes the required command series: Write Enable, the operation itself, then Read Status polling until Write-In-Progress clears or a poll budget runs out. The block sits between the host register interface and the SPI engine's 32-bit command port. It is the only writer of that port while it is busy.

## Interface
- POLL_GAP, 1000: idle clocks between successive Read Status commands (min 1)
- MAX_POLLS, 50000: Read Status commands issued before timeout (16-bit counter)
- ISSUE_WDOG, 8: clocks allowed for engine busy to rise after a command pulse
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  request strobe
- req_op  in  2  01 sector erase, 10 page program, 11 bulk erase, 00 ignored
- req_addr  in  24  flash byte address (unused for bulk erase)
- req_ready  out  1  high only in IDLE
- abort  in  1  level; request early termination
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- status  out  2  00 ok, 01 poll timeout, 10 aborted, 11 engine no-response; valid from done until next accept
- poll_count  out  16  Read Status commands issued in the last operation
- spi_cmd  out  32  command word to engine
- spi_cmd_wen  out  1  one-cycle command write strobe
- spi_busy  in  1  engine not idle
- spi_result  in  32  engine result; bits [7:0] = status register after Read Status

## Operation
- Command words:
  - WREN 0x06000000
  - SE {8'hD8, addr}
  - PP {8'h02, addr}; engine takes page data from its staged block buffer
  - BE 0xC7000000
  - RDSR 0x05000000
- States: IDLE, WREN_ISS, WREN_WAIT, OP_ISS, OP_WAIT, GAP, POLL_ISS, POLL_WAIT, DONE.
- IDLE:
  - req_valid && req_op != 00 latches op/addr, clears poll_count, status, abort flag → WREN_ISS.
  - req_op == 00 is not accepted; no done pulse.
- *_ISS: wait until spi_busy == 0, then drive spi_cmd and pulse spi_cmd_wen for exactly one cycle → matching *_WAIT.
- *_WAIT:
  - A seen_busy flag is cleared on entry and set when spi_busy == 1.
  - Exit when seen_busy && !spi_busy.
  - If spi_busy is not seen within ISSUE_WDOG clocks: status 11 → DONE.
- WREN_WAIT exit → OP_ISS.
- OP_WAIT exit → GAP; the gap counter loads POLL_GAP-1.
- GAP counts down to 0 → POLL_ISS; poll_count increments on each RDSR strobe.
- POLL_WAIT exit:
  - spi_result[0] == 0 → status 00, DONE.
  - Otherwise, if poll_count == MAX_POLLS → status 01, DONE.
  - Otherwise → GAP.
- Abort:
  - abort sampled high in any non-IDLE state sets a sticky flag.
  - In an *_ISS or GAP state the flag forces DONE with status 10 and no further strobe.
  - In a *_WAIT state the engine transaction always completes first. Then DONE with status 10, unless that same exit produces 11, which takes priority.
  - An abort after OP is issued leaves the flash mid-write; software must poll separately.
- DONE: done = 1 for one cycle → IDLE.
- poll_count saturates at MAX_POLLS and holds until the next accept.

## Timing
- Reset (reset == 0 at posedge) values:
  - state IDLE, busy 0, done 0, spi_cmd_wen 0, spi_cmd 0
  - status 00, poll_count 0, req_ready 1, all counters 0
- A reset mid-operation abandons the sequence immediately. The engine is reset by the same signal.
- Accept to first spi_cmd_wen: 1 clock if spi_busy is low.
- spi_cmd is held stable from the strobe cycle until the next strobe.
- Between a *_WAIT exit and the next strobe: at least 1 clock (the *_ISS state), plus POLL_GAP clocks before each RDSR.
- done fires 1 clock after the final WAIT exit; req_ready rises in the cycle after done.
- A req_valid during busy is ignored, with no queuing.

## Test plan
- Sector erase at 0x012345, engine model WIP=1 for 3 polls:
  - Expect strobes 0x06000000, 0xD8012345, then 4× 0x05000000 spaced ≥ POLL_GAP.
  - Expect done with status 00, poll_count 4.
- Bulk erase with WIP stuck at 1, MAX_POLLS = 5: exactly 5 RDSR strobes, then done, status 01, poll_count 5.
- Page program at 0x000100 with abort asserted during OP_WAIT:
  - OP transaction completes; no RDSR is issued.
  - done with status 10.
- Engine model never raises spi_busy after WREN: after ISSUE_WDOG clocks, done with status 11 and no further strobes.
- req_valid with op 00, then req_valid during busy: neither is accepted, no extra strobes; after done the next request is accepted normally.
- reset asserted during GAP: next clock shows busy 0, req_ready 1, spi_cmd_wen 0, status 00, poll_count 0.
